// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: iterative unsigned MULTU with HI/LO pair; define MULT_EARLY_TERM_EN to finish once the multiplier runs out of set bits
module mult_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d, sum;
  logic [WIDTH-1:0] mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last;
`ifdef MULT_EARLY_TERM_EN
  assign last = cnt_q == CNT_W'(WIDTH - 1) || mplier_q[WIDTH-1:1] == '0;
`else
  assign last = cnt_q == CNT_W'(WIDTH - 1);
`endif
  assign sum = prod_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == RUN) begin
      prod_d = sum;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        {hi_d, lo_d} = sum;
        state_d = DONE;
      end
    end else if (start) begin
      mcand_d = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      prod_d = '0;
      cnt_d = '0;
      state_d = RUN;
    end else begin
      hi_d = hi_we ? wdata : hi_q;
      lo_d = lo_we ? wdata : lo_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
